cmp_serial_lsb: RTL

Bit-serial unsigned magnitude comparator. It accepts two operands streamed as 2-bit digit pairs, least-significant digit first, over a valid/ready handshake. After the last digit it presents a one-hot registered result (`agtb`/`altb`/`aeqb`) on a second valid/ready handshake. It is the streaming, LSB-first counterpart to the team's parallel MSB-driven 2-bit greater-than comparator, and serves datapaths that deliver operands serially.

---
 rtl/cmp_serial_lsb.sv | 118 +++++++++++
 1 files changed

// File: rtl/cmp_serial_lsb.sv
// Bit-serial unsigned magnitude comparator: 2-bit digit pairs arrive LSB first,
// and a one-hot registered result is held on a valid/ready handshake.
module cmp_serial_lsb #(
  parameter int DIGITS = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  output logic in_ready,
  input  logic [1:0] a_dig,
  input  logic [1:0] b_dig,
  input  logic flush,
  output logic out_valid,
  input  logic out_ready,
  output logic agtb,
  output logic altb,
  output logic aeqb,
  output logic [((DIGITS > 1) ? $clog2(DIGITS) : 1)-1:0] dig_cnt
);

  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIGITS - 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;
  typedef enum logic [1:0] {REL_EQ = 2'd0, REL_GT = 2'd1, REL_LT = 2'd2} rel_t;

  state_t         state, state_nx;
  rel_t           rel, rel_nx, rel_upd;
  logic [CW-1:0]  cnt, cnt_nx;
  logic [2:0]     res, res_nx;

  function automatic logic [2:0] rel_to_res(input rel_t r);
    logic [2:0] v;
    case (r)
      REL_GT:  v = 3'b100;
      REL_LT:  v = 3'b010;
      default: v = 3'b001;
    endcase
    return v;
  endfunction

  // Next-state, running relation, digit counter and result latch.
  always_comb begin
    state_nx = state;
    rel_nx   = rel;
    cnt_nx   = cnt;
    res_nx   = res;
    // A differing digit always overrides: later digits are more significant.
    if (a_dig > b_dig) begin
      rel_upd = REL_GT;
    end else if (a_dig < b_dig) begin
      rel_upd = REL_LT;
    end else begin
      rel_upd = rel;
    end

    if (flush) begin
      state_nx = ACCUM;
      rel_nx   = REL_EQ;
      cnt_nx   = CNT_ZERO;
    end else begin
      case (state)
        ACCUM: begin
          if (in_valid) begin
            rel_nx = rel_upd;
            if (cnt == CNT_LAST) begin
              state_nx = HOLD;
              cnt_nx   = CNT_ZERO;
              res_nx   = rel_to_res(rel_upd);
            end else begin
              cnt_nx = cnt + CNT_ONE;
            end
          end else begin
            state_nx = ACCUM;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_nx = ACCUM;
            rel_nx   = REL_EQ;
          end else begin
            state_nx = HOLD;
          end
        end
        default: begin
          state_nx = ACCUM;
          rel_nx   = REL_EQ;
          cnt_nx   = CNT_ZERO;
        end
      endcase
    end
  end

  // State, relation, counter and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACCUM;
      rel   <= REL_EQ;
      cnt   <= CNT_ZERO;
      res   <= 3'b001;
    end else begin
      state <= state_nx;
      rel   <= rel_nx;
      cnt   <= cnt_nx;
      res   <= res_nx;
    end
  end

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == HOLD);
  assign agtb      = res[2];
  assign altb      = res[1];
  assign aeqb      = res[0];
  assign dig_cnt   = cnt;

endmodule
